// File: rtl/amba_apb_arb_pkg.sv
// Shared types and default sizes for the APB request arbiter and its neighbours.
package amba_apb_arb_pkg;

    localparam int NUM_REQ_DEF     = 2;
    localparam int ADDR_W_DEF      = 8;
    localparam int DATA_W_DEF      = 8;
    localparam int TIMEOUT_CYC_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WAIT_ACC,
        RESP
    } arb_state_e;

    // Default-width command; the arbiter builds a parameter-width twin of this.
    typedef struct packed {
        logic                  write;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } arb_cmd_t;

endpackage

// File: rtl/amba_apb_req_arbiter_if.sv
// Request/response and APB-master command bundle between bus agents, the arbiter and the APB master.
interface amba_apb_req_arbiter_if
    import amba_apb_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;

    logic                      transfer;
    logic                      mpwrite;
    logic [ADDR_W-1:0]         apb_write_paddr;
    logic [DATA_W-1:0]         apb_write_data;
    logic [ADDR_W-1:0]         apb_read_paddr;
    logic                      psel;
    logic                      penable;
    logic [DATA_W-1:0]         apb_read_data_out;

    // The arbiter is the slave of the requesters and observes the APB master.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  psel, penable, apb_read_data_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output transfer, mpwrite, apb_write_paddr, apb_write_data, apb_read_paddr
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output psel, penable, apb_read_data_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  transfer, mpwrite, apb_write_paddr, apb_write_data, apb_read_paddr
    );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin picker: first set request bit searching upward from last+1, wrapping.
module apb_rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Scan farthest-first so the nearest candidate after last is written last and wins.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req[IDX_W'((int'(last) + k) % N)]) begin
                grant_idx   = IDX_W'((int'(last) + k) % N);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/amba_apb_req_arbiter.sv
// Round-robin sharing of one APB master command port, one full transfer per grant.
// Define APB_ARB_TIMEOUT_EN to add a TIMEOUT_CYC watchdog that ends stalled transfers with rsp_err.
module amba_apb_req_arbiter
    import amba_apb_arb_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
`ifdef APB_ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
`endif
    parameter int DATA_W      = DATA_W_DEF
) (
    input logic                   pclk,
    input logic                   preset,
    amba_apb_req_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_reg_t;

    arb_state_e         state_q, state_n;
    logic [IDX_W-1:0]   last_q, last_n;
    logic [IDX_W-1:0]   gnt_q, gnt_n;
    cmd_reg_t           cmd_q, cmd_n;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_n;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_n;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_n;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               access_done;
    logic               cmd_active;
    logic [ADDR_W-1:0]  req_addr_a  [NUM_REQ];
    logic [DATA_W-1:0]  req_wdata_a [NUM_REQ];

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               timed_out_q, timed_out_n;
    logic               rsp_err_q, rsp_err_n;
    logic               expired;

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_addr_a[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
        assign req_wdata_a[i] = bus.req_wdata[i*DATA_W +: DATA_W];
    end

    apb_rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req         (bus.req_valid),
        .last        (last_q),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    assign access_done = bus.psel && bus.penable;

    // Next-state logic; arbitration only looks at req_valid while IDLE.
    always_comb begin
        state_n     = state_q;
        last_n      = last_q;
        gnt_n       = gnt_q;
        cmd_n       = cmd_q;
        req_ready_n = '0;
        rsp_valid_n = '0;
        rsp_rdata_n = rsp_rdata_q;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_n       = cnt_q;
        timed_out_n = timed_out_q;
        rsp_err_n   = rsp_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_n               = CMD;
                    last_n                = pick_idx;
                    gnt_n                 = pick_idx;
                    cmd_n.write           = bus.req_write[pick_idx];
                    cmd_n.addr            = req_addr_a[pick_idx];
                    cmd_n.wdata           = req_wdata_a[pick_idx];
                    req_ready_n[pick_idx] = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                    cnt_n                 = '0;
                    timed_out_n           = 1'b0;
`endif
                end
            end
            CMD: begin
                if (bus.psel) begin
                    state_n = WAIT_ACC;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (expired) begin
                    state_n     = RESP;
                    timed_out_n = 1'b1;
                end
                cnt_n = cnt_q + 1'b1;
`endif
            end
            WAIT_ACC: begin
                if (access_done) begin
                    state_n = RESP;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (expired) begin
                    state_n     = RESP;
                    timed_out_n = 1'b1;
                end
                cnt_n = cnt_q + 1'b1;
`endif
            end
            RESP: begin
                state_n             = IDLE;
                rsp_valid_n[gnt_q]  = 1'b1;
                rsp_rdata_n         = cmd_q.write ? '0 : bus.apb_read_data_out;
`ifdef APB_ARB_TIMEOUT_EN
                if (timed_out_q) begin
                    rsp_rdata_n = '0;
                end
                rsp_err_n = timed_out_q;
`endif
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            cmd_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_n;
            last_q      <= last_n;
            gnt_q       <= gnt_n;
            cmd_q       <= cmd_n;
            req_ready_q <= req_ready_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_rdata_q <= rsp_rdata_n;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q       <= cnt_n;
            timed_out_q <= timed_out_n;
            rsp_err_q   <= rsp_err_n;
`endif
        end
    end

    // Command fields are decoded from the latched command, so they read 0 whenever IDLE.
    assign cmd_active          = (state_q != IDLE);
    assign bus.transfer        = (state_q == CMD);
    assign bus.mpwrite         = cmd_active && cmd_q.write;
    assign bus.apb_write_paddr = (cmd_active && cmd_q.write)  ? cmd_q.addr  : '0;
    assign bus.apb_write_data  = (cmd_active && cmd_q.write)  ? cmd_q.wdata : '0;
    assign bus.apb_read_paddr  = (cmd_active && !cmd_q.write) ? cmd_q.addr  : '0;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
`ifdef APB_ARB_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: doc/amba_apb_req_arbiter.md
Name: amba_apb_req_arbiter

Overview:
- Shares the single APB master command port (transfer / mpwrite / write address / write data / read address) between NUM_REQ requesters.
- Arbitrates round-robin and sequences one complete APB transfer per grant.
- Detects completion from the master's psel/penable.
- Returns read data or write completion to the granted requester.
- Sits between bus-agent logic and the APB master inside the top-level APB subsystem.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 8, APB address width.
- DATA_W, 8, APB data width.
- TIMEOUT_CYC, 16, watchdog limit in cycles; used only with APB_ARB_TIMEOUT_EN.

Ports:
- pclk  in  1  clock; all logic on posedge.
- preset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- req_ready  out  NUM_REQ  one-cycle pulse: request accepted.
- rsp_valid  out  NUM_REQ  one-cycle pulse: transfer finished.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- transfer  out  1  start command to the APB master.
- mpwrite  out  1  direction to the master.
- apb_write_paddr  out  ADDR_W  write address.
- apb_write_data  out  DATA_W  write data.
- apb_read_paddr  out  ADDR_W  read address.
- psel  in  1  master select, observed.
- penable  in  1  master enable, observed.
- apb_read_data_out  in  DATA_W  master's registered read data.

Behaviour:
- Clock and reset: one clock, pclk. preset is synchronous and active-high.
- Reset values: all outputs 0; FSM = IDLE; round-robin pointer last = NUM_REQ-1, so requester 0 wins first.
- Reset mid-operation: abandons the transfer immediately. No rsp_valid is issued for it.
- FSM states: IDLE, CMD, WAIT_ACC, RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from last+1 with wrap-around.
  - Register the winner's write/addr/wdata into the command registers and pulse its req_ready.
  - Set last = winner and go to CMD.
  - Arbitration happens only in IDLE. req_valid changes at any other time are ignored.
- CMD:
  - transfer = 1; mpwrite = latched write.
  - Write: apb_write_paddr / apb_write_data = latched values, apb_read_paddr = 0.
  - Read: apb_read_paddr = latched addr, write fields = 0.
  - Move to WAIT_ACC in the first cycle psel = 1; transfer drops in that next cycle.
- WAIT_ACC:
  - Address, data and mpwrite stay stable.
  - Completion is the first cycle with psel && penable. The slave has no wait states; access lasts one cycle.
  - Then go to RESP.
- RESP (one cycle):
  - Pulse rsp_valid[granted].
  - rsp_rdata = apb_read_data_out for reads, 0 for writes.
  - rsp_err = 0. Clear the command outputs and return to IDLE.
- Latency: req_valid sampled in IDLE → req_ready pulses at the next edge. With the master asserting psel 1 cycle after transfer, rsp_valid appears 4 cycles after req_ready. Back-to-back grants are separated by one IDLE cycle.
- rsp_rdata and rsp_err hold their values until the next RESP.
- A requester that keeps req_valid high after req_ready is treated as a new request.
- Fairness: with all requesters asserted, grants rotate 0,1,…,NUM_REQ-1,0.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- With it:
  - A counter starts on entry to CMD.
  - If TIMEOUT_CYC cycles pass without psel && penable, drop transfer and go to RESP.
  - In that RESP, rsp_valid is pulsed with rsp_err = 1 and rsp_rdata = 0.
- Without it: there is no counter, rsp_err is tied 0, and the FSM waits indefinitely.

Decomposition:
- Package amba_apb_arb_pkg holds:
  - state enum arb_state_e {IDLE, CMD, WAIT_ACC, RESP};
  - localparam defaults;
  - command struct {write, addr, wdata}.
- One sub-module, apb_rr_arbiter: a combinational round-robin picker taking req vector and last pointer, returning grant index and valid. It is reused elsewhere.

Test Plan:
- Reset, then req_valid=2'b01, write, addr 0x10, data 0xA5 → req_ready[0] pulse; mpwrite=1, apb_write_paddr=0x10, apb_write_data=0xA5; rsp_valid[0] after psel&&penable; rsp_rdata=0.
- Read req1 addr 0x22 with slave returning 0x5C → apb_read_paddr=0x22; rsp_valid[1] with rsp_rdata=0x5C.
- Both requesters held high for 4 grants → grant order 0,1,0,1; each rsp_valid matches its own grant.
- Assert preset while in WAIT_ACC → next cycle all outputs 0; no rsp_valid; next grant goes to requester 0.
- Change req_addr mid-transfer → command outputs unchanged until RESP.
- APB_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, psel never asserted → at cycle 16 transfer=0; rsp_valid with rsp_err=1, rsp_rdata=0.
